// File: rtl/definitions_pkg.sv
// Shared fetch-path types: address/instruction words, fetch FSM states, buffer entry layout.
// The legality helper is the single place that encodes the text-segment bounds.
package definitions_pkg;

  localparam int ADDR_W = 16;

  typedef logic [ADDR_W-1:0] word_ut;
  typedef logic [31:0]       word_32ut;

  localparam word_ut   TEXT_ORG  = 16'h0000;
  localparam word_ut   TEXT_END  = 16'h0100;
  localparam word_32ut NOP_INSTR = 32'h0000_0013;

  typedef enum logic {FETCH, HALT} fetch_state_e;

  typedef struct packed {
    word_ut   pc;
    word_32ut instr;
    logic     fault;
  } fetch_entry_t;

  // Bounds are checked one bit wider so pc+4 cannot wrap past TEXT_END unnoticed.
  function automatic logic pc_legal(word_ut pc);
    logic [ADDR_W:0] pc_end;
    logic [ADDR_W:0] pc_off;
    pc_end = {1'b0, pc} + (ADDR_W+1)'(4);
    pc_off = {1'b0, pc} - {1'b0, TEXT_ORG};
    return (pc[1:0] == 2'b00) && !pc_off[ADDR_W] && (pc_end <= {1'b0, TEXT_END});
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of fetch entries; head is a register so outputs carry no logic.
// Latency 1 cycle push-to-head; flush overrides push/pop; caller must not push when full without popping.
module fetch_buffer
  import definitions_pkg::*;
#(
  parameter word_ut RESET_PC = TEXT_ORG
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t head_q;
  fetch_entry_t tail_q;
  logic [1:0]   count_q;
  logic         pop_ok;

  assign pop_ok = pop && (count_q != 2'd0);
  assign count  = count_q;
  assign head   = head_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      head_q  <= '{pc: RESET_PC, instr: NOP_INSTR, fault: 1'b0};
      tail_q  <= '{pc: RESET_PC, instr: NOP_INSTR, fault: 1'b0};
    end else if (flush) begin
      count_q <= 2'd0;
    end else if (push && !pop_ok) begin
      if (count_q == 2'd0) head_q <= push_entry;
      else                 tail_q <= push_entry;
      count_q <= count_q + 2'd1;
    end else if (!push && pop_ok) begin
      // Head keeps its last contents when the buffer empties.
      if (count_q == 2'd2) head_q <= tail_q;
      count_q <= count_q - 2'd1;
    end else if (push && pop_ok) begin
      if (count_q == 2'd2) begin
        head_q <= tail_q;
        tail_q <= push_entry;
      end else begin
        head_q <= push_entry;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: drives the RAM address from pc_q and queues returned words for decode.
// Latency 1 cycle fetch/redirect to valid; stalls fetch while the buffer is full and not draining.
module instr_fetch_unit
  import definitions_pkg::*;
#(
  parameter word_ut RESET_PC  = TEXT_ORG,
  parameter int     BUF_DEPTH = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  output word_ut   imem_a_o,
  input  word_32ut imem_d_i,
  input  logic     redirect_i,
  input  word_ut   redirect_pc_i,
  output logic     instr_valid_o,
  input  logic     instr_ready_i,
  output word_32ut instr_o,
  output word_ut   instr_pc_o,
  output logic     instr_fault_o
);

  localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

  fetch_state_e state_q;
  word_ut       pc_q;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         handshake;
  logic         legal;
  logic         enq;

  assign imem_a_o      = pc_q;
  assign instr_valid_o = (count != 2'd0);
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
  assign instr_fault_o = head.fault;

  assign handshake  = instr_valid_o && instr_ready_i;
  assign legal      = pc_legal(pc_q);
  assign enq        = (state_q == FETCH) && !redirect_i && ((count < BUF_FULL) || handshake);
  assign push_entry = legal ? '{pc: pc_q, instr: imem_d_i,  fault: 1'b0}
                            : '{pc: pc_q, instr: NOP_INSTR, fault: 1'b1};

  // An illegal PC is queued once as a fault marker and fetch parks until redirected.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else if (redirect_i) begin
      state_q <= FETCH;
      pc_q    <= redirect_pc_i;
    end else if (enq) begin
      if (legal) pc_q    <= pc_q + word_ut'(4);
      else       state_q <= HALT;
    end
  end

  fetch_buffer #(
    .RESET_PC (RESET_PC)
  ) u_fetch_buffer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push       (enq),
    .push_entry (push_entry),
    .pop        (handshake),
    .flush      (redirect_i),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; RAM word at address a reads as 0xA000_0000 | a.
module tb_instr_fetch_unit;
  import definitions_pkg::*;

  logic     clk_i = 1'b0;
  logic     rst_ni;
  word_ut   imem_a_o;
  word_32ut imem_d_i;
  logic     redirect_i;
  word_ut   redirect_pc_i;
  logic     instr_valid_o;
  logic     instr_ready_i;
  word_32ut instr_o;
  word_ut   instr_pc_o;
  logic     instr_fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  assign imem_d_i = (imem_a_o[15:8] == 8'h00) ? {16'hA000, imem_a_o} : 32'hDEAD_BEEF;

  instr_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_a_o      (imem_a_o),
    .imem_d_i      (imem_d_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_fault_o (instr_fault_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc,
                             input logic [31:0] ins, input logic flt);
    check_eq({tag, ".valid"}, 32'(instr_valid_o), 32'h1);
    check_eq({tag, ".pc"},    32'(instr_pc_o),    pc);
    check_eq({tag, ".instr"}, instr_o,            ins);
    check_eq({tag, ".fault"}, 32'(instr_fault_o), 32'(flt));
  endtask

  task automatic do_redirect(input word_ut target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    step();
    check_eq("redir_flush.valid", 32'(instr_valid_o), 32'h0);
    redirect_i = 1'b0;
  endtask

  initial begin
    rst_ni        = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b1;
    #1 rst_ni = 1'b0;
    #1;
    check_eq("rst.valid", 32'(instr_valid_o), 32'h0);
    check_eq("rst.instr", instr_o,            32'h0000_0013);
    check_eq("rst.pc",    32'(instr_pc_o),    32'h0);
    check_eq("rst.fault", 32'(instr_fault_o), 32'h0);
    check_eq("rst.imem_a", 32'(imem_a_o),     32'h0);
    step();
    step();
    check_eq("rst_hold.valid", 32'(instr_valid_o), 32'h0);
    rst_ni = 1'b1;

    // Streaming from reset, one word per cycle.
    step(); expect_head("seq0", 32'h0, 32'hA000_0000, 1'b0);
    step(); expect_head("seq1", 32'h4, 32'hA000_0004, 1'b0);
    step(); expect_head("seq2", 32'h8, 32'hA000_0008, 1'b0);
    step(); expect_head("seq3", 32'hC, 32'hA000_000C, 1'b0);

    // Backpressure: buffer fills to two, fetch parks at 0x8.
    instr_ready_i = 1'b0;
    do_redirect(16'h0000);
    step(); expect_head("bp_first", 32'h0, 32'hA000_0000, 1'b0);
    repeat (4) step();
    expect_head("bp_hold", 32'h0, 32'hA000_0000, 1'b0);
    check_eq("bp_hold.imem_a", 32'(imem_a_o), 32'h8);
    instr_ready_i = 1'b1;
    step(); expect_head("bp_rel1", 32'h4, 32'hA000_0004, 1'b0);
    step(); expect_head("bp_rel2", 32'h8, 32'hA000_0008, 1'b0);

    // Redirect with full buffer and active handshake.
    do_redirect(16'h0040);
    step(); expect_head("redir40", 32'h40, 32'hA000_0040, 1'b0);

    // Misaligned target: single fault entry, then halt until redirected.
    do_redirect(16'h0042);
    step(); expect_head("mis42", 32'h42, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("halt.valid",  32'(instr_valid_o), 32'h0);
      check_eq("halt.imem_a", 32'(imem_a_o),      32'h42);
    end
    do_redirect(16'h0010);
    step(); expect_head("resume10", 32'h10, 32'hA000_0010, 1'b0);

    // End of text segment: last two legal words then a fault at TEXT_END.
    do_redirect(16'h00F8);
    step(); expect_head("endF8",  32'hF8,  32'hA000_00F8, 1'b0);
    step(); expect_head("endFC",  32'hFC,  32'hA000_00FC, 1'b0);
    step(); expect_head("end100", 32'h100, 32'h0000_0013, 1'b1);
    step();
    check_eq("end_halt.valid", 32'(instr_valid_o), 32'h0);

    // Asynchronous reset with two entries buffered.
    instr_ready_i = 1'b0;
    do_redirect(16'h0020);
    step();
    step();
    expect_head("pre_rst", 32'h20, 32'hA000_0020, 1'b0);
    check_eq("pre_rst.imem_a", 32'(imem_a_o), 32'h28);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst.valid",  32'(instr_valid_o), 32'h0);
    check_eq("arst.instr",  instr_o,            32'h0000_0013);
    check_eq("arst.pc",     32'(instr_pc_o),    32'h0);
    check_eq("arst.fault",  32'(instr_fault_o), 32'h0);
    check_eq("arst.imem_a", 32'(imem_a_o),      32'h0);
    rst_ni        = 1'b1;
    instr_ready_i = 1'b1;
    step(); expect_head("restart0", 32'h0, 32'hA000_0000, 1'b0);
    step(); expect_head("restart1", 32'h4, 32'hA000_0004, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Sequences the instruction RAM.
- Holds the fetch PC and drives the RAM's combinational read address.
- Captures each returned instruction word into a 2-entry buffer, presented to decode with a valid/ready handshake.
- Handles redirects from execute, and flags misaligned or out-of-range fetch addresses in order, as a tagged entry.

## Interface

Parameters:
- RESET_PC, default TEXT_ORG: fetch address loaded on reset.
- BUF_DEPTH, default 2: fetch buffer entries; fixed at 2, other values unsupported.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- imem_a_o  output  word_ut  instruction RAM address; equals pc_q.
- imem_d_i  input  word_32ut  instruction RAM read data; combinational from imem_a_o.
- redirect_i  input  1  control-flow change from execute.
- redirect_pc_i  input  word_ut  target PC; sampled when redirect_i=1.
- instr_valid_o  output  1  buffer head valid.
- instr_ready_i  input  1  decode accepts head.
- instr_o  output  word_32ut  head instruction.
- instr_pc_o  output  word_ut  head PC.
- instr_fault_o  output  1  head is a fetch-fault entry.

## Operation

- A fetch address is legal iff pc[1:0]==0, pc >= TEXT_ORG and pc+4 <= TEXT_END.
- States:
  - FETCH: issue fetches.
  - HALT: faulted; no fetch.
- Reset → FETCH, pc_q=RESET_PC.
- Enqueue condition, each cycle: state==FETCH, no redirect, and (count<2 or head handshake this cycle).
  - pc_q legal: push {pc_q, imem_d_i, fault=0}; pc_q += 4.
  - pc_q illegal: push {pc_q, NOP_INSTR, fault=1}; pc_q unchanged; go to HALT.
- Dequeue: instr_valid_o && instr_ready_i pops the head.
- Simultaneous enqueue and dequeue with count==2: both occur; count stays 2.
- Redirect has priority over everything:
  - Buffer flushed (count=0); any same-cycle handshake is discarded by the flush.
  - pc_q=redirect_pc_i; state→FETCH, including from HALT.
  - No enqueue that cycle.
- In HALT, the buffer drains normally; no new entries until a redirect arrives.
- pc_q arithmetic is word_ut width and wraps. The wrapped value fails the legality check, so a fault entry is produced.
- Empty buffer: instr_valid_o=0. instr_o/instr_pc_o/instr_fault_o hold the last head contents and are don't-care for decode.

## Timing

- Reset values:
  - instr_valid_o=0
  - instr_o=NOP_INSTR (0x0000_0013)
  - instr_pc_o=RESET_PC
  - instr_fault_o=0
  - imem_a_o=RESET_PC
- First instruction valid on the first rising edge after rst_ni deasserts.
- Fetch-to-valid latency: 1 cycle.
- Redirect-to-valid latency: 1 cycle; the target instruction is valid on the second edge after redirect_i is sampled.
- Throughput: 1 instruction/cycle while instr_ready_i=1.
- instr_valid_o, instr_o, instr_pc_o and instr_fault_o are registered (buffer outputs).
- No combinational path from instr_ready_i to any output; instr_ready_i affects only next-state.
- Reset asserted mid-operation: buffer cleared and outputs return to reset values immediately (asynchronous); pending entries are lost.

## Structure

In definitions_pkg:
- NOP_INSTR (32'h0000_0013).
- fetch_state_e (FETCH, HALT).
- fetch_entry_t struct: pc word_ut, instr word_32ut, fault logic.

Sub-module fetch_buffer:
- 2-entry FIFO of fetch_entry_t.
- Ports: push, pop, flush, count, head.
- Same clock/reset.
- flush has priority over push/pop.

The FSM, pc_q and legality check live in instr_fetch_unit.

## Test plan

- Reset release with TEXT_ORG=0x0, RAM holding words W0..W3, instr_ready_i=1 → instr_valid_o=1 from cycle 1; PCs 0x0,0x4,0x8,0xC with W0..W3 on consecutive cycles.
- Backpressure:
  - instr_ready_i=0 for 5 cycles → count saturates at 2; head stays PC 0x0; imem_a_o holds 0x8.
  - instr_ready_i rises → 0x0,0x4,0x8 delivered back-to-back with no bubble.
- Redirect to 0x40 while buffer is full and a handshake is active → both buffered entries dropped; next valid is PC 0x40 two edges later.
- Redirect to 0x42 (misaligned) → one entry: PC 0x42, instr_o=0x0000_0013, instr_fault_o=1. Then instr_valid_o=0 indefinitely; a redirect to 0x10 resumes fetch.
- Sequential fetch reaching TEXT_END → last legal word delivered, then a fault entry at PC=TEXT_END.
- rst_ni asserted mid-stream with 2 entries buffered → instr_valid_o=0 asynchronously; after release, restart from RESET_PC.
